gesture_window_scheduler: RTL and testbench
===========================================

# gesture_window_scheduler

Sequences the voxel-bin classification datapath. It times fixed accumulation windows and counts accepted DVS events. When a window holds enough events, it freezes the accumulator, launches the classifier and waits for its result. It then clears the accumulator and, after a confirmed gesture from the output persistence filter, holds off new accumulation for a refractory period. It sits between the event front-end and the accumulator/classifier/output-register chain.

## Interface
- WINDOW_CYCLES, 1200000: accumulation window length in clk cycles (≥2)
- MIN_EVENTS, 20: minimum events in a window for classification to run
- CLASS_TIMEOUT, 64: maximum cycles spent waiting for class_valid (≥2)
- REFRACTORY_CYCLES, 2400000: hold-off after a confirmed gesture (≥1)
- CNT_BITS, 24: width of window/timeout/refractory counters
- EVT_BITS, 16: width of event counter
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request
- event_strobe  in  1  one accepted event this cycle
- class_valid  in  1  classifier result strobe
- gesture_valid_in  in  1  confirmed-gesture pulse from the persistence filter
- acc_freeze  out  1  accumulator must ignore events while high
- class_start  out  1  one-cycle classifier launch pulse
- acc_clear  out  1  one-cycle accumulator clear pulse
- event_count  out  EVT_BITS  events counted in the current window
- window_id  out  8  completed-window counter
- timeout_err  out  1  sticky classifier timeout flag
- debug_state  out  3  current state encoding

## Operation
- States: IDLE=0, ACCUM=1, CLOSE=2, CLASSIFY=3, CLEAR=4, REFRACT=5.
- acc_freeze is a Moore decode of the state: it is 1 in every state except ACCUM.
- class_start is high only in CLOSE. acc_clear is high only in CLEAR.
- IDLE: when enable=1, go to ACCUM with the timer and event_count zeroed.
- ACCUM:
  - The timer increments every cycle.
  - event_strobe increments event_count, saturating at 2^EVT_BITS−1.
  - A strobe on the terminal cycle counts toward that window.
  - On the cycle where timer==WINDOW_CYCLES−1, the window closes. The count used is event_count plus the current strobe. If that count is ≥MIN_EVENTS, go to CLOSE; otherwise go to CLEAR, skipping classification.
  - If enable=0 in ACCUM, go to CLEAR and then IDLE.
- CLOSE: lasts one cycle, then goes to CLASSIFY with the wait counter at 0.
- CLASSIFY: leaves on class_valid=1 and goes to CLEAR.
  - If the wait counter reaches CLASS_TIMEOUT−1 with no class_valid, set timeout_err and go to CLEAR.
  - timeout_err clears only on reset.
  - enable=0 here does not abort; the state runs to CLEAR.
- CLEAR: lasts one cycle. window_id increments, wrapping 255→0. Exit is decided in this order:
  1. enable=0 → IDLE.
  2. refract_pending or gesture_valid_in high this cycle → REFRACT, with refract_pending cleared.
  3. Otherwise → ACCUM, with the timer and event_count zeroed.
- REFRACT: counts REFRACTORY_CYCLES cycles, then goes to ACCUM with counters zeroed. Events are not counted. enable=0 goes directly to IDLE; no clear is needed because the accumulator is already empty.
- gesture_valid_in seen in any state other than CLEAR sets refract_pending. refract_pending is consumed at the next CLEAR.
- class_valid outside CLASSIFY is ignored.
- event_count holds its value through CLOSE, CLASSIFY and CLEAR. It is zeroed on entry to ACCUM.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE, acc_freeze=1, class_start=0, acc_clear=0, event_count=0, window_id=0, timeout_err=0, debug_state=0, refract_pending=0.
- All outputs are registered; no combinational path from any input to any output.
- Window closing at ACCUM cycle t:
  - class_start is high at t+1 (CLOSE).
  - CLASSIFY is active from t+2.
- class_valid sampled at CLASSIFY cycle c:
  - acc_clear is high at c+1.
  - ACCUM resumes at c+2, with acc_freeze low.
- Skipped (sparse) window:
  - The ACCUM period is exactly WINDOW_CYCLES cycles plus 1 CLEAR cycle.
- Timeout: CLEAR is entered CLASS_TIMEOUT cycles after entry to CLASSIFY.
- The persistence filter emits gesture_valid one cycle after class_valid. That is the CLEAR cycle, which is why the CLEAR exit decision uses gesture_valid_in in the same cycle.
- rst_n deasserted mid-window aborts immediately. acc_freeze reasserts asynchronously.

## Test plan
Parameters for all scenarios: WINDOW_CYCLES=16, MIN_EVENTS=4, CLASS_TIMEOUT=8, REFRACTORY_CYCLES=10.
- Dense window: enable=1; 5 strobes in window; class_valid 3 cycles after class_start → exactly one class_start pulse, then acc_clear one cycle after class_valid; event_count=5 held until the clear; window_id 0→1; ACCUM resumes.
- Sparse window: 3 strobes, with the last one on the terminal cycle → no class_start; acc_clear on cycle 17; repeat period is 17 cycles. Same test with 4 strobes (last on terminal cycle) → class_start fires.
- Timeout: dense window, class_valid never asserted → acc_clear 8 cycles after CLASSIFY entry; timeout_err=1 and stays 1 through later windows.
- Refractory: gesture_valid_in pulsed in the CLEAR cycle → REFRACT (debug_state=5) for 10 cycles with acc_freeze=1 and strobes ignored, then ACCUM. gesture_valid_in pulsed during ACCUM → REFRACT follows the next CLEAR.
- Enable drop: enable=0 during CLASSIFY → class_valid still completes, then CLEAR→IDLE. enable=0 in ACCUM → CLEAR pulse, then IDLE.
- Reset mid-CLASSIFY: rst_n=0 → every output at its reset value immediately (asynchronous); after release with enable=1, the first ACCUM starts at window_id=0.

Source files
------------

// File: rtl/gesture_window_scheduler.sv
// Scheduler for the voxel-bin classification chain: times accumulation windows,
// counts events, launches the classifier, clears the accumulator, applies refractory hold-off.
module gesture_window_scheduler #(
    parameter int WINDOW_CYCLES     = 1200000,
    parameter int MIN_EVENTS        = 20,
    parameter int CLASS_TIMEOUT     = 64,
    parameter int REFRACTORY_CYCLES = 2400000,
    parameter int CNT_BITS          = 24,
    parameter int EVT_BITS          = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                event_strobe,
    input  logic                class_valid,
    input  logic                gesture_valid_in,
    output logic                acc_freeze,
    output logic                class_start,
    output logic                acc_clear,
    output logic [EVT_BITS-1:0] event_count,
    output logic [7:0]          window_id,
    output logic                timeout_err,
    output logic [2:0]          debug_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ACCUM    = 3'd1;
    localparam logic [2:0] S_CLOSE    = 3'd2;
    localparam logic [2:0] S_CLASSIFY = 3'd3;
    localparam logic [2:0] S_CLEAR    = 3'd4;
    localparam logic [2:0] S_REFRACT  = 3'd5;

    localparam logic [CNT_BITS-1:0] WIN_LAST = CNT_BITS'(WINDOW_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] TMO_LAST = CNT_BITS'(CLASS_TIMEOUT - 1);
    localparam logic [CNT_BITS-1:0] REF_LAST = CNT_BITS'(REFRACTORY_CYCLES - 1);
    localparam logic [EVT_BITS-1:0] MIN_EVT  = EVT_BITS'(MIN_EVENTS);

    logic [2:0]          state_q, state_d;
    logic [CNT_BITS-1:0] timer_q, timer_d;
    logic [EVT_BITS-1:0] event_count_q, event_count_d, event_inc;
    logic [7:0]          window_id_q, window_id_d;
    logic                timeout_err_q, timeout_err_d;
    logic                refract_pending_q, refract_pending_d;

    always_comb begin
        state_d           = state_q;
        timer_d           = timer_q;
        event_count_d     = event_count_q;
        window_id_d       = window_id_q;
        timeout_err_d     = timeout_err_q;
        refract_pending_d = refract_pending_q;
        // Terminal-cycle strobe must count toward the closing window, so the
        // close decision looks at the incremented value.
        event_inc = (event_strobe && event_count_q != '1) ? event_count_q + EVT_BITS'(1)
                                                          : event_count_q;

        if (gesture_valid_in && state_q != S_CLEAR)
            refract_pending_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d       = S_ACCUM;
                    timer_d       = '0;
                    event_count_d = '0;
                end
            end
            S_ACCUM: begin
                event_count_d = event_inc;
                timer_d       = timer_q + CNT_BITS'(1);
                if (!enable)
                    state_d = S_CLEAR;
                else if (timer_q == WIN_LAST)
                    state_d = (event_inc >= MIN_EVT) ? S_CLOSE : S_CLEAR;
            end
            S_CLOSE: begin
                state_d = S_CLASSIFY;
                timer_d = '0;
            end
            S_CLASSIFY: begin
                timer_d = timer_q + CNT_BITS'(1);
                if (class_valid) begin
                    state_d = S_CLEAR;
                end else if (timer_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_CLEAR;
                end
            end
            S_CLEAR: begin
                window_id_d = window_id_q + 8'd1;
                // Same-cycle gesture_valid_in: the filter answers one cycle after class_valid.
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (refract_pending_q || gesture_valid_in) begin
                    state_d           = S_REFRACT;
                    refract_pending_d = 1'b0;
                    timer_d           = '0;
                end else begin
                    state_d       = S_ACCUM;
                    timer_d       = '0;
                    event_count_d = '0;
                end
            end
            S_REFRACT: begin
                timer_d = timer_q + CNT_BITS'(1);
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (timer_q == REF_LAST) begin
                    state_d       = S_ACCUM;
                    timer_d       = '0;
                    event_count_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            timer_q           <= '0;
            event_count_q     <= '0;
            window_id_q       <= '0;
            timeout_err_q     <= 1'b0;
            refract_pending_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            timer_q           <= timer_d;
            event_count_q     <= event_count_d;
            window_id_q       <= window_id_d;
            timeout_err_q     <= timeout_err_d;
            refract_pending_q <= refract_pending_d;
        end
    end

    assign acc_freeze  = (state_q != S_ACCUM);
    assign class_start = (state_q == S_CLOSE);
    assign acc_clear   = (state_q == S_CLEAR);
    assign event_count = event_count_q;
    assign window_id   = window_id_q;
    assign timeout_err = timeout_err_q;
    assign debug_state = state_q;

endmodule

// File: tb/tb_gesture_window_scheduler.sv
// Bench for gesture_window_scheduler: directed scenarios plus random traffic,
// all compared cycle-by-cycle against a countdown-based reference model.
module tb_gesture_window_scheduler;
    localparam int WC = 16, ME = 4, CT = 8, RC = 10;
    localparam int EVT_MAX = 65535;

    logic clk = 1'b0, rst_n = 1'b0;
    logic enable = 1'b0, event_strobe = 1'b0, class_valid = 1'b0, gesture_valid_in = 1'b0;
    logic acc_freeze, class_start, acc_clear, timeout_err;
    logic [15:0] event_count;
    logic [7:0] window_id;
    logic [2:0] debug_state;

    gesture_window_scheduler #(
        .WINDOW_CYCLES(WC), .MIN_EVENTS(ME), .CLASS_TIMEOUT(CT),
        .REFRACTORY_CYCLES(RC), .CNT_BITS(24), .EVT_BITS(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .event_strobe(event_strobe),
        .class_valid(class_valid), .gesture_valid_in(gesture_valid_in),
        .acc_freeze(acc_freeze), .class_start(class_start), .acc_clear(acc_clear),
        .event_count(event_count), .window_id(window_id), .timeout_err(timeout_err),
        .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cs_seen = 0;

    // Reference: phase number plus "cycles left" countdowns per phase.
    int m_st, m_left, m_cnt, m_wid;
    bit m_terr, m_pend;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_left = 0; m_cnt = 0; m_wid = 0; m_terr = 0; m_pend = 0;
    endtask

    task automatic model_step(input bit en, input bit stb, input bit cv, input bit gv);
        int nst = m_st;
        bit pend_in = m_pend | gv;
        if (gv && m_st != 4) m_pend = 1;
        case (m_st)
            0: if (en) begin nst = 1; m_left = WC; m_cnt = 0; end
            1: begin
                if (stb && m_cnt < EVT_MAX) m_cnt++;
                m_left--;
                if (!en) nst = 4;
                else if (m_left == 0) nst = (m_cnt >= ME) ? 2 : 4;
            end
            2: begin nst = 3; m_left = CT; end
            3: begin
                m_left--;
                if (cv) nst = 4;
                else if (m_left == 0) begin m_terr = 1; nst = 4; end
            end
            4: begin
                m_wid = (m_wid + 1) % 256;
                if (!en) nst = 0;
                else if (pend_in) begin m_pend = 0; nst = 5; m_left = RC; end
                else begin nst = 1; m_left = WC; m_cnt = 0; end
            end
            5: begin
                m_left--;
                if (!en) nst = 0;
                else if (m_left == 0) begin nst = 1; m_left = WC; m_cnt = 0; end
            end
            default: nst = 0;
        endcase
        m_st = nst;
    endtask

    task automatic cmp_model();
        chk("acc_freeze", acc_freeze, (m_st != 1));
        chk("class_start", class_start, (m_st == 2));
        chk("acc_clear", acc_clear, (m_st == 4));
        chk("event_count", event_count, m_cnt);
        chk("window_id", window_id, m_wid);
        chk("timeout_err", timeout_err, m_terr);
        chk("debug_state", debug_state, m_st);
        if (class_start) cs_seen++;
    endtask

    // Called at posedge+1; drives inputs for the current cycle and samples after the next edge.
    task automatic tick(input bit en, input bit stb, input bit cv, input bit gv);
        enable = en; event_strobe = stb; class_valid = cv; gesture_valid_in = gv;
        model_step(en, stb, cv, gv);
        @(posedge clk); #1;
        cmp_model();
    endtask

    // One full window from ACCUM entry; optionally the last strobe lands on the terminal cycle.
    task automatic run_window(input int nstb, input bit last_on_term);
        chk("win_start_state", debug_state, 1);
        for (int i = 0; i < WC; i++) begin
            bit s;
            if (last_on_term) s = (i < nstb - 1) || (i == WC - 1);
            else              s = (i < nstb);
            tick(1, s, 0, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cs0, pstb;
        model_reset();
        @(posedge clk); #1;
        chk("rst_freeze", acc_freeze, 1);
        chk("rst_state", debug_state, 0);
        chk("rst_wid", window_id, 0);
        rst_n = 1'b1;
        tick(0, 1, 0, 0);
        chk("idle_hold", debug_state, 0);

        // Dense window, class_valid 3 cycles after class_start
        cs_seen = 0;
        tick(1, 0, 0, 0);
        run_window(5, 0);
        chk("dense_cs", class_start, 1);
        chk("dense_cnt", event_count, 5);
        tick(1, 0, 0, 0); tick(1, 0, 0, 0); tick(1, 0, 0, 0);
        tick(1, 0, 1, 0);
        chk("dense_clear", acc_clear, 1);
        chk("dense_cnt_held", event_count, 5);
        chk("dense_wid_before", window_id, 0);
        tick(1, 0, 0, 0);
        chk("dense_resume", acc_freeze, 0);
        chk("dense_wid_after", window_id, 1);
        chk("dense_cs_count", cs_seen, 1);

        // Sparse: 3 strobes, last on terminal cycle -> skip classification
        cs0 = cs_seen;
        run_window(3, 1);
        chk("sparse_clear", acc_clear, 1);
        chk("sparse_no_cs", cs_seen, cs0);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1, 0, 0, 0);
            if (acc_clear) begin n = i; break; end
        end
        chk("sparse_period", n, 17);
        tick(1, 0, 0, 0);
        run_window(4, 1);
        chk("four_cs", class_start, 1);
        tick(1, 0, 0, 0);
        tick(1, 0, 1, 0);
        tick(1, 0, 0, 0);

        // Timeout
        run_window(5, 0);
        tick(1, 0, 0, 0);
        chk("tmo_in_classify", debug_state, 3);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1, 0, 0, 0);
            if (acc_clear) begin n = i; break; end
        end
        chk("tmo_latency", n, CT);
        chk("tmo_flag", timeout_err, 1);
        tick(1, 0, 0, 0);

        // Refractory after gesture in CLEAR; strobes during REFRACT ignored
        run_window(5, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 1, 0);
        tick(1, 0, 0, 1);
        chk("refr_state", debug_state, 5);
        chk("refr_freeze", acc_freeze, 1);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick(1, 1, 0, 0);
            if (debug_state == 3'd5) n++;
            else break;
        end
        chk("refr_len", n, RC);
        chk("refr_exit_state", debug_state, 1);
        chk("refr_exit_cnt", event_count, 0);

        // Gesture during ACCUM -> refractory after next CLEAR
        tick(1, 0, 0, 1);
        for (int i = 1; i < WC; i++) tick(1, 0, 0, 0);
        chk("pend_clear", acc_clear, 1);
        tick(1, 0, 0, 0);
        chk("pend_refract", debug_state, 5);
        for (int i = 0; i < 20; i++) begin
            if (debug_state == 3'd1) break;
            tick(1, 0, 0, 0);
        end

        // Enable drop during CLASSIFY, then in ACCUM
        run_window(5, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("endrop_classify", debug_state, 3);
        tick(0, 0, 1, 0);
        chk("endrop_clear", acc_clear, 1);
        tick(0, 0, 0, 0);
        chk("endrop_idle", debug_state, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0); tick(1, 0, 0, 0); tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("accdrop_clear", acc_clear, 1);
        tick(0, 0, 0, 0);
        chk("accdrop_idle", debug_state, 0);
        chk("tmo_sticky", timeout_err, 1);

        // Random traffic with varying event density
        pstb = 50;
        for (int i = 0; i < 3000; i++) begin
            bit en;
            if (i % 64 == 0) begin
                case ($urandom_range(0, 3))
                    0: pstb = 0;
                    1: pstb = 10;
                    2: pstb = 40;
                    default: pstb = 90;
                endcase
            end
            en = enable ? ($urandom_range(0, 149) != 0) : ($urandom_range(0, 3) == 0);
            tick(en, $urandom_range(0, 99) < pstb, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 24) == 0);
        end

        // Reset in the middle of CLASSIFY
        for (int i = 0; i < 200; i++) begin
            if (debug_state == 3'd3) break;
            tick(1, 1, 0, 0);
        end
        chk("reach_classify", debug_state, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_freeze", acc_freeze, 1);
        chk("arst_cs", class_start, 0);
        chk("arst_clear", acc_clear, 0);
        chk("arst_cnt", event_count, 0);
        chk("arst_wid", window_id, 0);
        chk("arst_terr", timeout_err, 0);
        chk("arst_state", debug_state, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1, 0, 0, 0);
        chk("post_rst_accum", debug_state, 1);
        chk("post_rst_wid", window_id, 0);
        run_window(2, 0);
        tick(1, 0, 0, 0);
        chk("post_rst_wid1", window_id, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
